// File: rtl/alu_multiword_seq_pkg.sv
// Shared definitions for the multi-word add/subtract sequencer.
//   - op encodings presented on the 'op' port
//   - EXE_CMD codes understood by the 32-bit execute-stage ALU
//   - sequencer state enum
//   - bit positions inside a {N,Z,C,V} flag nibble
package alu_multiword_seq_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ADC = 2'b10,
        OP_SBC = 2'b11
    } op_e;

    localparam logic [3:0] CMD_NOP = 4'b0000;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_multiword_seq.sv
// Multi-word add/subtract sequencer.
// Drives the external 32-bit ALU one word per cycle (least-significant word
// first), chaining carry/borrow through ADC/SBC, and returns a wide result
// with ARM-style {N,Z,C,V} flags.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, op, cin      request (taken when ready=1), operation, ARM carry-in
//   a_in, b_in          NWORDS x 32-bit operands, sampled at accept
//   ready, done         idle indicator, one-cycle completion pulse
//   result, flags       registered wide result and {N,Z,C,V}, held until next accept
//   alu_a/b/cmd/cin     operands and command to the ALU (combinational from state)
//   alu_result, alu_sr  ALU result and status, same cycle (only C is used)
module alu_multiword_seq
    import alu_multiword_seq_pkg::*;
#(
    parameter int NWORDS = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [1:0]             op,
    input  logic                   cin,
    input  logic [32*NWORDS-1:0]   a_in,
    input  logic [32*NWORDS-1:0]   b_in,
    output logic                   ready,
    output logic                   done,
    output logic [32*NWORDS-1:0]   result,
    output logic [3:0]             flags,
    output logic [31:0]            alu_a,
    output logic [31:0]            alu_b,
    output logic [3:0]             alu_cmd,
    output logic                   alu_cin,
    input  logic [31:0]            alu_result,
    input  logic [3:0]             alu_sr
);

    localparam int KW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NWORDS - 1);

    state_e                   state;
    logic [NWORDS-1:0][31:0]  a_q;
    logic [NWORDS-1:0][31:0]  b_q;
    logic [NWORDS-1:0][31:0]  res_q;
    logic [1:0]               op_q;
    logic [KW-1:0]            k;
    logic                     cy;     // carry for add, borrow for subtract
    logic                     zacc;   // all words so far were zero

    logic accept;
    logic is_sub;
    logic c_new;
    logic z_word;
    logic unused_sr;

    // Signed-overflow rule on the top word; subtraction flips the operand-sign test.
    function automatic logic calc_v(input logic sub, input logic a31,
                                    input logic b31, input logic r31);
        if (sub)
            return (a31 != b31) && (r31 != a31);
        else
            return (a31 == b31) && (r31 != a31);
    endfunction

    assign accept    = (state == ST_IDLE) && start;
    assign is_sub    = op_q[0];                 // SUB and SBC share bit 0
    assign c_new     = alu_sr[FLAG_C];
    assign z_word    = (alu_result == 32'd0);
    assign result    = res_q;
    assign unused_sr = ^{alu_sr[FLAG_N], alu_sr[FLAG_Z], alu_sr[FLAG_V]};

    // ALU drive: first word of plain ADD/SUB uses the carry-less command,
    // every other word chains through ADC/SBC.
    always_comb begin
        alu_a   = 32'd0;
        alu_b   = 32'd0;
        alu_cmd = CMD_NOP;
        alu_cin = 1'b0;
        if (state == ST_RUN) begin
            alu_a = a_q[k];
            alu_b = b_q[k];
            if (is_sub) begin
                if ((k == '0) && !op_q[1]) begin
                    alu_cmd = CMD_SUB;
                end else begin
                    alu_cmd = CMD_SBC;
                    alu_cin = ~cy;              // ALU SBC takes ARM carry (1 = no borrow)
                end
            end else begin
                if ((k == '0) && !op_q[1]) begin
                    alu_cmd = CMD_ADD;
                end else begin
                    alu_cmd = CMD_ADC;
                    alu_cin = cy;
                end
            end
        end
    end

    // Operand capture: plain data registers, loaded only on accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q  <= a_in;
            b_q  <= b_in;
            op_q <= op;
        end
    end

    // Sequencer FSM with registered handshake, result and flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            ready <= 1'b1;
            done  <= 1'b0;
            res_q <= '0;
            flags <= 4'b0000;
            k     <= '0;
            cy    <= 1'b0;
            zacc  <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_RUN;
                        ready <= 1'b0;
                        k     <= '0;
                        zacc  <= 1'b1;
                        case (op)
                            OP_ADC:  cy <= cin;
                            OP_SBC:  cy <= ~cin;    // borrow = not ARM carry
                            default: cy <= 1'b0;
                        endcase
                    end
                end
                ST_RUN: begin
                    res_q[k] <= alu_result;
                    cy       <= c_new;
                    zacc     <= zacc & z_word;
                    k        <= k + 1'b1;
                    if (k == K_LAST) begin
                        state         <= ST_DONE;
                        done          <= 1'b1;
                        flags[FLAG_N] <= alu_result[31];
                        flags[FLAG_Z] <= zacc & z_word;
                        flags[FLAG_C] <= is_sub ? ~c_new : c_new;
                        flags[FLAG_V] <= calc_v(is_sub, a_q[k][31], b_q[k][31],
                                                alu_result[31]);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    ready <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_multiword_seq.md
# alu_multiword_seq

Sequencer that performs multi-word (NWORDS × 32-bit) add/subtract by driving the existing 32-bit ALU one word per cycle, least-significant word first, chaining carry/borrow through its ADC/SBC commands. It sits beside the execute-stage ALU, owns the ALU inputs while busy, and returns a wide result plus ARM-style NZCV flags through a start/ready/done handshake.

## Interface
- NWORDS, 2, number of 32-bit words per operand; legal range 1..8
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; accepted only on a rising edge where ready=1
- op  in  2  00 ADD, 01 SUB, 10 ADC (word 0 uses cin), 11 SBC (word 0 uses cin)
- cin  in  1  ARM carry-in for op ADC/SBC (SBC: 1 = no borrow)
- a_in, b_in  in  32*NWORDS  operands, word i = bits [32i+31:32i]; sampled at accept
- ready  out  1  idle, can accept start
- done  out  1  one-cycle pulse, result/flags valid
- result  out  32*NWORDS  registered result, held until next accept
- flags  out  4  {N,Z,C,V}, registered, held until next accept
- alu_a, alu_b  out  32  ALU operands (combinational from state)
- alu_cmd  out  4  ALU EXE_CMD
- alu_cin  out  1  ALU carry input
- alu_result  in  32  ALU result, same cycle
- alu_sr  in  4  ALU {N,Z,C,V}, same cycle; only bit 1 (C) is used

## Operation
- States: IDLE → RUN (on accepted start) → DONE (after word NWORDS-1 captured) → IDLE (unconditionally, next cycle).
- At accept: latch a_in, b_in, op into A, B, OP; word counter k←0; carry register cy initialised: ADD/SUB → 0; ADC → cin; SBC → ~cin (cy holds borrow for subtracts); zacc←1.
- RUN, word k: alu_a=A[k], alu_b=B[k]. Command: ADD path uses 0010 (ADD) when k=0 and op=ADD, else 0011 (ADC) with alu_cin=cy. SUB path uses 0100 (SUB) when k=0 and op=SUB, else 0101 (SBC) with alu_cin=~cy.
- Each RUN edge: result word k←alu_result; cy←alu_sr[1] (carry for add, borrow for subtract); zacc←zacc & (alu_result==0); k←k+1.
- Flags, captured on last RUN edge: N=alu_result[31]; Z=zacc & (alu_result==0); C=cy_new for add, ~cy_new for subtract (ARM convention); V computed locally from top word: add: (A[31]==B[31]) & (res[31]!=A[31]); subtract: (A[31]!=B[31]) & (res[31]!=A[31]). ALU V is ignored.
- IDLE/DONE: alu_cmd=0000, alu_a=alu_b=0, alu_cin=0.
- start while ready=0 is ignored (not queued). a_in/b_in changes after accept have no effect.
- Arithmetic wraps modulo 2^(32*NWORDS).

## Timing
- Reset (async): state IDLE, ready=1, done=0, result=0, flags=0, k=0, cy=0, zacc=1.
- Accept at edge E0 → ready=0 from E0; word k captured at edge E(k+1); DONE entered at E(NWORDS); done=1 for exactly the cycle E(NWORDS)..E(NWORDS+1); ready=1 again from E(NWORDS+1).
- Latency start-to-done: NWORDS cycles; throughput: one operation per NWORDS+1 cycles.
- NWORDS=1: single RUN cycle; flags from that word.
- Reset asserted mid-RUN: operation aborted, all outputs return to reset values immediately; no done pulse.

## Structure
- Shared package: op encodings, EXE_CMD constants (ADD 0010, ADC 0011, SUB 0100, SBC 0101, NOP 0000), state enum, flag bit indices.
- No sub-module; the ALU stays outside and is connected at the parent. Bench instantiates the existing ALU behind the alu_* ports.

## Test plan
- NWORDS=2, ADD a=0x00000000_FFFFFFFF, b=0x1 → result 0x00000001_00000000, flags 0000, done exactly 2 cycles after accept.
- SUB a=0x00000001_00000000, b=0x1 → 0x00000000_FFFFFFFF, flags N0 Z0 C1 V0; SUB a=0, b=1 → 0xFFFFFFFF_FFFFFFFF, N1 Z0 C0 V0.
- SUB a=b=0x12345678_9ABCDEF0 → 0, flags N0 Z1 C1 V0; ADD a=0x7FFFFFFF_FFFFFFFF, b=1 → 0x80000000_00000000, N1 Z0 C0 V1.
- ADC cin=1, a=0xFFFFFFFF_FFFFFFFF, b=0 → 0, Z1 C1; SBC cin=0, a=5, b=2 → 2, C1.
- start pulsed during RUN and DONE with different operands → ignored, first result intact, one done pulse only.
- rst asserted in RUN word 0 → ready=1, done never pulses, result=0; next start completes normally.
